// File: rtl/fp_sign_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sign_unit
//  Description : Result-sign and effective-operation logic for the FP add/sub
//                datapath, optionally registered with a valid qualifier.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_sign_unit #(
    parameter int OUT_REG = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    input  logic i_add_sub,
    input  logic i_comp_man,
    input  logic i_sign_man_a,
    input  logic i_sign_man_b,
    input  logic i_exact_zero,
    output logic o_sign_s,
    output logic o_eff_sub,
    output logic o_valid
);

    logic w_sb_eff;
    logic w_eff_sub;
    logic w_sign;

    // An exact cancellation of opposite-signed magnitudes always yields +0.
    always_comb begin
        w_sb_eff  = i_sign_man_b ^ i_add_sub;
        w_eff_sub = i_sign_man_a ^ w_sb_eff;
        if (!w_eff_sub) begin
            w_sign = i_sign_man_a;
        end else if (i_exact_zero) begin
            w_sign = 1'b0;
        end else if (i_comp_man) begin
            w_sign = i_sign_man_a;
        end else begin
            w_sign = w_sb_eff;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic r_sign_s_q;
            logic r_eff_sub_q;
            logic r_valid_q;
            logic w_sign_s_d;
            logic w_eff_sub_d;
            logic w_valid_d;

            // Data only loads on valid cycles so idle-cycle garbage never leaks out.
            always_comb begin
                w_sign_s_d  = r_sign_s_q;
                w_eff_sub_d = r_eff_sub_q;
                w_valid_d   = i_valid;
                if (i_valid) begin
                    w_sign_s_d  = w_sign;
                    w_eff_sub_d = w_eff_sub;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sign_s_q  <= 1'b0;
                    r_eff_sub_q <= 1'b0;
                    r_valid_q   <= 1'b0;
                end else begin
                    r_sign_s_q  <= w_sign_s_d;
                    r_eff_sub_q <= w_eff_sub_d;
                    r_valid_q   <= w_valid_d;
                end
            end

            assign o_sign_s  = r_sign_s_q;
            assign o_eff_sub = r_eff_sub_q;
            assign o_valid   = r_valid_q;
        end else begin : g_comb
            assign o_sign_s  = w_sign;
            assign o_eff_sub = w_eff_sub;
            assign o_valid   = i_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fp_sign_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_sign_unit
//  Description : Scoreboard bench for fp_sign_unit against a signed-arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_sign_unit;

    logic clk;
    logic rst;
    logic i_valid, i_add_sub, i_comp_man, i_sign_man_a, i_sign_man_b, i_exact_zero;
    logic o_sign_s, o_eff_sub, o_valid;

    int total;
    int bad;

    typedef struct packed {
        logic sign;
        logic eff;
    } exp_t;

    exp_t exp_q[$];

    fp_sign_unit #(.OUT_REG(1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .i_add_sub    (i_add_sub),
        .i_comp_man   (i_comp_man),
        .i_sign_man_a (i_sign_man_a),
        .i_sign_man_b (i_sign_man_b),
        .i_exact_zero (i_exact_zero),
        .o_sign_s     (o_sign_s),
        .o_eff_sub    (o_eff_sub),
        .o_valid      (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Reference: pick concrete magnitudes consistent with the compare/zero
    // flags, add the signed values, and read the sign off the sum.
    function automatic exp_t model(input logic [4:0] v);
        logic add_sub, comp, a, b, zero;
        int   mag_a, mag_b, val_a, val_b, sum;
        exp_t e;
        {add_sub, comp, a, b, zero} = v;
        if (zero)      begin mag_a = 3; mag_b = 3; end
        else if (comp) begin mag_a = 5; mag_b = 2; end
        else           begin mag_a = 2; mag_b = 5; end
        val_a = a ? -mag_a : mag_a;
        val_b = (b != add_sub) ? -mag_b : mag_b;
        e.eff = ((val_a < 0) != (val_b < 0));
        if (!e.eff) begin
            e.sign = a;
        end else begin
            if (zero) sum = 0;
            else      sum = val_a + val_b;
            e.sign = (sum < 0);
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic r, input logic [4:0] bits);
        @(posedge clk);
        #1;
        rst     = r;
        i_valid = v;
        {i_add_sub, i_comp_man, i_sign_man_a, i_sign_man_b, i_exact_zero} = bits;
        if (v && !r) exp_q.push_back(model(bits));
    endtask

    // Monitor: tracks reset at each edge and checks outputs mid-cycle.
    logic rst_s;
    int   edges;
    exp_t held;

    initial begin
        rst_s = 1'b0;
        edges = 0;
        held  = '0;
    end

    always @(posedge clk) begin
        rst_s = rst;
        edges = edges + 1;
    end

    always @(negedge clk) begin
        if (edges > 0) begin
            if (rst_s) begin
                chk("reset_valid", o_valid, 1'b0);
                chk("reset_sign", o_sign_s, 1'b0);
                chk("reset_eff", o_eff_sub, 1'b0);
                held = '0;
            end else if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", o_valid, 1'b0);
                end else begin
                    held = exp_q.pop_front();
                    chk("sign_s", o_sign_s, held.sign);
                    chk("eff_sub", o_eff_sub, held.eff);
                end
            end else begin
                chk("hold_sign", o_sign_s, held.sign);
                chk("hold_eff", o_eff_sub, held.eff);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        i_valid = 1'b0;
        {i_add_sub, i_comp_man, i_sign_man_a, i_sign_man_b, i_exact_zero} = '0;

        // Reset held two cycles with valid data presented; it must be discarded.
        drive(1'b1, 1'b1, 5'b00110);
        drive(1'b1, 1'b1, 5'b10011);

        // Directed cases: {add_sub, comp, a, b, zero}
        drive(1'b1, 1'b0, 5'b00110);
        drive(1'b1, 1'b0, 5'b10000);
        drive(1'b1, 1'b0, 5'b11000);
        drive(1'b1, 1'b0, 5'b11111);
        drive(1'b1, 1'b0, 5'b10101);
        drive(1'b1, 1'b0, 5'b00111);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 5'(i));

        // Hold/gap: one result, then idle cycles with toggling inputs.
        drive(1'b1, 1'b0, 5'b00110);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 5'($urandom_range(0, 31)));

        // Random traffic with gaps.
        for (int i = 0; i < 80; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'b0, 5'($urandom_range(0, 31)));

        // Reset mid-stream, with valid data present during the reset cycle.
        drive(1'b1, 1'b0, 5'b00110);
        drive(1'b1, 1'b1, 5'b00110);
        drive(1'b0, 1'b0, 5'b11111);
        drive(1'b0, 1'b0, 5'b00000);

        // Resume after reset.
        for (int i = 0; i < 20; i++)
            drive(1'($urandom_range(0, 1)), 1'b0, 5'($urandom_range(0, 31)));
        drive(1'b0, 1'b0, 5'b00000);
        drive(1'b0, 1'b0, 5'b00000);
        @(negedge clk);
        #1;

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
